cordic_rotate_qo: RTL and testbench

- Pipelined CORDIC rotation-mode block: converts polar input (magnitude, angle in 0..pi/2 plus quadrant code) to rectangular re/im.
- Inverse of the team's CORDIC atan/magnitude vectoring block. Uses the same angle formats, quadrant coding and per-stage angle table, so vectoring output can be fed back here to regenerate the original vector.
- Used for NCO/phase-rotation paths in the OFDM chain.

---
 rtl/cordic_rotate_qo.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_cordic_rotate_qo.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotate_qo.sv
// ----------------------------------------------------------------------------
// cordic_rotate_qo
//
// Pipelined CORDIC rotation-mode converter: polar (magnitude, angle within a
// quadrant plus a quadrant code) to rectangular (re, im). It is the inverse
// of the CORDIC vectoring block and shares its angle formats, quadrant coding
// and per-stage arctangent table. Vectoring output can therefore be fed back
// here to rebuild the original vector.
//
// Parameters
//   pTYPE  : angle format. 0 = binary (2^30 = pi/2), 1 = radians [0.29],
//            2 = degrees [6.23].
//   pITER  : number of CORDIC iterations, 1..20.
//   pANG_W : input angle width. The angle is aligned to 30 bits internally.
//   pMAG_W : input magnitude width (unsigned).
//   pDAT_W : output re/im width (signed, symmetric saturation).
//
// Ports
//   iclk     : clock
//   ireset   : asynchronous active-high reset (valid line and outputs only)
//   iclkena  : pipeline clock enable; low freezes every register
//   ival     : input sample valid
//   iquart   : quadrant code, 00 = I, 01 = II, 11 = III, 10 = IV
//   iangle   : angle within the quadrant, unsigned, format per pTYPE
//   imag     : magnitude, unsigned
//   oval     : output valid
//   odat_re  : real part, signed; holds the last valid result
//   odat_im  : imaginary part, signed; holds the last valid result
//
// Optional feature
//   CORDIC_ROTATE_GAIN_COMP_EN : when defined, an extra register stage scales
//   the result by 1/K (79594 / 2^17) so the output magnitude matches imag.
//   Latency grows from pITER+2 to pITER+3 enabled clocks.
// ----------------------------------------------------------------------------
module cordic_rotate_qo #(
    parameter int pTYPE  = 0,
    parameter int pITER  = 20,
    parameter int pANG_W = 30,
    parameter int pMAG_W = 18,
    parameter int pDAT_W = 20
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     ival,
    input  logic [1:0]               iquart,
    input  logic [pANG_W-1:0]        iangle,
    input  logic [pMAG_W-1:0]        imag,
    output logic                     oval,
    output logic signed [pDAT_W-1:0] odat_re,
    output logic signed [pDAT_W-1:0] odat_im
);

    // Internal x/y width: magnitude, two bits of CORDIC growth headroom and
    // pITER fractional bits.
    localparam int cW  = pMAG_W + 2 + pITER;
    // Width of x/y once the fractional bits are dropped.
    localparam int cSW = pMAG_W + 2;
    // Width used for quadrant negation and saturation; wide enough that
    // negating the most negative scaled value cannot overflow.
    localparam int cEW = (((cSW + 1) > pDAT_W) ? (cSW + 1) : pDAT_W) + 1;

`ifdef CORDIC_ROTATE_GAIN_COMP_EN
    localparam int cNV = pITER + 2;
`else
    localparam int cNV = pITER + 1;
`endif

    // Largest legal in-quadrant angle code (pi/2) for each format.
    localparam logic [29:0] cANG_MAX = (pTYPE == 1) ? 30'd843314856 :
                                       (pTYPE == 2) ? 30'd754974720 :
                                                      30'h3FFF_FFFF;

    localparam logic signed [cEW-1:0] cSAT_P =
        {{(cEW - pDAT_W + 1){1'b0}}, {(pDAT_W - 1){1'b1}}};
    localparam logic signed [cEW-1:0] cSAT_N = -cSAT_P;

    // Per-stage arctangent table. The binary row is stored; the radian and
    // degree rows are derived from it (rad = bin * pi/4, deg = bin * 45/64),
    // which keeps the three rows consistent with the vectoring block.
    function automatic logic [30:0] atan_tab(input int idx);
        logic [63:0] b;
        case (idx)
            0:       b = 64'h2000_0000;
            1:       b = 64'h12E4_051E;
            2:       b = 64'h09FB_385B;
            3:       b = 64'h0511_11D4;
            4:       b = 64'h028B_0D43;
            5:       b = 64'h0145_D7E1;
            6:       b = 64'h00A2_F61E;
            7:       b = 64'h0051_7C55;
            8:       b = 64'h0028_BE53;
            9:       b = 64'h0014_5F2F;
            10:      b = 64'h000A_2F98;
            11:      b = 64'h0005_17CC;
            12:      b = 64'h0002_8BE6;
            13:      b = 64'h0001_45F3;
            14:      b = 64'h0000_A2F9;
            15:      b = 64'h0000_517C;
            16:      b = 64'h0000_28BE;
            17:      b = 64'h0000_145F;
            18:      b = 64'h0000_0A2F;
            19:      b = 64'h0000_0518;
            default: b = 64'h0;
        endcase
        case (pTYPE)
            1:       b = (b * 64'd843314857 + 64'd536870912) >> 30;
            2:       b = (b * 64'd45 + 64'd32) >> 6;
            default: b = b;
        endcase
        return 31'(b);
    endfunction

    // Pipeline state. Index 0 is the input stage, index i+1 the result of
    // iteration i. The residual angle is only needed up to the last
    // iteration's input.
    logic signed [cW-1:0] x_q     [0:pITER];
    logic signed [cW-1:0] x_d     [0:pITER];
    logic signed [cW-1:0] y_q     [0:pITER];
    logic signed [cW-1:0] y_d     [0:pITER];
    logic signed [30:0]   z_q     [0:pITER-1];
    logic signed [30:0]   z_d     [0:pITER-1];
    logic [1:0]           quart_q [0:pITER];
    logic [1:0]           quart_d [0:pITER];

    logic [cNV-1:0] val_q;
    logic [cNV-1:0] val_d;

    logic                     oval_q;
    logic                     oval_d;
    logic signed [pDAT_W-1:0] odat_re_q;
    logic signed [pDAT_W-1:0] odat_re_d;
    logic signed [pDAT_W-1:0] odat_im_q;
    logic signed [pDAT_W-1:0] odat_im_d;

    logic [29:0] ang_al;
    logic [29:0] ang_cl;

    // Align the incoming angle to 30 bits.
    generate
        if (pANG_W < 30) begin : g_ang_pad
            assign ang_al = {iangle, {(30 - pANG_W){1'b0}}};
        end else begin : g_ang_trunc
            assign ang_al = iangle[pANG_W-1 -: 30];
        end
    endgenerate

    // Input stage and the CORDIC iterations. Both x and y updates use the
    // previous stage's values; the direction follows the residual's sign.
    always_comb begin
        ang_cl = (ang_al > cANG_MAX) ? cANG_MAX : ang_al;

        if (ival) begin
            x_d[0]     = $signed({{(cW - pMAG_W){1'b0}}, imag}) <<< pITER;
            y_d[0]     = '0;
            z_d[0]     = $signed({1'b0, ang_cl});
            quart_d[0] = iquart;
        end else begin
            x_d[0]     = x_q[0];
            y_d[0]     = y_q[0];
            z_d[0]     = z_q[0];
            quart_d[0] = quart_q[0];
        end

        for (int i = 0; i < pITER; i++) begin
            if (!z_q[i][30]) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
            end
            quart_d[i+1] = quart_q[i];
        end

        for (int i = 0; i < pITER - 1; i++) begin
            if (!z_q[i][30]) begin
                z_d[i+1] = z_q[i] - $signed(atan_tab(i));
            end else begin
                z_d[i+1] = z_q[i] + $signed(atan_tab(i));
            end
        end

        val_d = {val_q[cNV-2:0], ival};
    end

    // Drop the fractional bits (arithmetic shift = floor).
    logic signed [cSW-1:0] xs;
    logic signed [cSW-1:0] ys;
    logic signed [cSW-1:0] xf;
    logic signed [cSW-1:0] yf;
    logic [1:0]            qf;

    assign xs = cSW'(x_q[pITER] >>> pITER);
    assign ys = cSW'(y_q[pITER] >>> pITER);

`ifdef CORDIC_ROTATE_GAIN_COMP_EN
    // 1/K scaled by 2^17. The product is taken at full width so the shift
    // back down is a plain floor.
    localparam logic signed [17:0] cGAIN = 18'sd79594;

    logic signed [cSW+17:0] prod_x;
    logic signed [cSW+17:0] prod_y;
    logic signed [cSW-1:0]  xc_q;
    logic signed [cSW-1:0]  xc_d;
    logic signed [cSW-1:0]  yc_q;
    logic signed [cSW-1:0]  yc_d;
    logic [1:0]             qc_q;
    logic [1:0]             qc_d;

    always_comb begin
        prod_x = (cSW + 18)'(xs) * (cSW + 18)'(cGAIN);
        prod_y = (cSW + 18)'(ys) * (cSW + 18)'(cGAIN);
        xc_d   = cSW'(prod_x >>> 17);
        yc_d   = cSW'(prod_y >>> 17);
        qc_d   = quart_q[pITER];
    end

    assign xf = xc_q;
    assign yf = yc_q;
    assign qf = qc_q;
`else
    assign xf = xs;
    assign yf = ys;
    assign qf = quart_q[pITER];
`endif

    // Quadrant mapping and symmetric saturation. The output registers only
    // take a new value when the last valid bit says a sample has arrived.
    logic signed [cEW-1:0] xe;
    logic signed [cEW-1:0] ye;
    logic signed [cEW-1:0] re_e;
    logic signed [cEW-1:0] im_e;
    logic signed [cEW-1:0] re_s;
    logic signed [cEW-1:0] im_s;

    always_comb begin
        xe = {{(cEW - cSW){xf[cSW-1]}}, xf};
        ye = {{(cEW - cSW){yf[cSW-1]}}, yf};

        case (qf)
            2'b00:   begin re_e = xe;  im_e = ye;  end
            2'b01:   begin re_e = -ye; im_e = xe;  end
            2'b11:   begin re_e = -xe; im_e = -ye; end
            default: begin re_e = ye;  im_e = -xe; end
        endcase

        if (re_e > cSAT_P) begin
            re_s = cSAT_P;
        end else if (re_e < cSAT_N) begin
            re_s = cSAT_N;
        end else begin
            re_s = re_e;
        end

        if (im_e > cSAT_P) begin
            im_s = cSAT_P;
        end else if (im_e < cSAT_N) begin
            im_s = cSAT_N;
        end else begin
            im_s = im_e;
        end

        oval_d    = val_q[cNV-1];
        odat_re_d = val_q[cNV-1] ? pDAT_W'(re_s) : odat_re_q;
        odat_im_d = val_q[cNV-1] ? pDAT_W'(im_s) : odat_im_q;
    end

    // Datapath stages carry no reset; stale contents are harmless because
    // the valid line is cleared.
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            for (int k = 0; k <= pITER; k++) begin
                x_q[k]     <= x_d[k];
                y_q[k]     <= y_d[k];
                quart_q[k] <= quart_d[k];
            end
            for (int k = 0; k < pITER; k++) begin
                z_q[k] <= z_d[k];
            end
`ifdef CORDIC_ROTATE_GAIN_COMP_EN
            xc_q <= xc_d;
            yc_q <= yc_d;
            qc_q <= qc_d;
`endif
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            val_q     <= '0;
            oval_q    <= 1'b0;
            odat_re_q <= '0;
            odat_im_q <= '0;
        end else if (iclkena) begin
            val_q     <= val_d;
            oval_q    <= oval_d;
            odat_re_q <= odat_re_d;
            odat_im_q <= odat_im_d;
        end
    end

    assign oval    = oval_q;
    assign odat_re = odat_re_q;
    assign odat_im = odat_im_q;

endmodule

// File: tb/tb_cordic_rotate_qo.sv
// ----------------------------------------------------------------------------
// tb_cordic_rotate_qo
//
// Self-checking bench for cordic_rotate_qo. A floating-point polar-to-
// rectangular model (gain K, optional 1/K compensation, saturation) gives the
// expected values; fixed test-plan points are checked against constants.
// A second instance with pDAT_W = 19 exercises output saturation.
// ----------------------------------------------------------------------------
module tb_cordic_rotate_qo;

`ifdef CORDIC_ROTATE_GAIN_COMP_EN
    localparam int  cLAT  = 23;
    localparam bit  cCOMP = 1'b1;
    localparam int  cE0   = 10000;
    localparam int  cE45  = 7071;
`else
    localparam int  cLAT  = 22;
    localparam bit  cCOMP = 1'b0;
    localparam int  cE0   = 16468;
    localparam int  cE45  = 11644;
`endif

    logic               iclk    = 1'b0;
    logic               ireset  = 1'b1;
    logic               iclkena = 1'b1;
    logic               ival    = 1'b0;
    logic [1:0]         iquart  = 2'b00;
    logic [29:0]        iangle  = '0;
    logic [17:0]        imag    = '0;
    logic               oval;
    logic signed [19:0] odat_re;
    logic signed [19:0] odat_im;
    logic               oval19;
    logic signed [18:0] re19;
    logic signed [18:0] im19;

    int  errors = 0;
    int  checks = 0;
    real gain;

    cordic_rotate_qo dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (ival),
        .iquart  (iquart),
        .iangle  (iangle),
        .imag    (imag),
        .oval    (oval),
        .odat_re (odat_re),
        .odat_im (odat_im)
    );

    cordic_rotate_qo #(.pDAT_W(19)) dut19 (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (ival),
        .iquart  (iquart),
        .iangle  (iangle),
        .imag    (imag),
        .oval    (oval19),
        .odat_re (re19),
        .odat_im (im19)
    );

    always #5 iclk = ~iclk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    // Ideal result: gain * mag * exp(j*theta), theta = angle + k*pi/2.
    task automatic model(input int mag, input logic [29:0] ang, input logic [1:0] q,
                         input int dw, output real re, output real im);
        int  k;
        real th;
        real lim;
        case (q)
            2'b00:   k = 0;
            2'b01:   k = 1;
            2'b11:   k = 2;
            default: k = 3;
        endcase
        th  = (real'(ang) / 1073741824.0 + real'(k)) * 1.5707963267948966;
        lim = (2.0 ** (dw - 1)) - 1.0;
        re  = gain * real'(mag) * $cos(th);
        im  = gain * real'(mag) * $sin(th);
        if (re > lim) re = lim;
        if (re < -lim) re = -lim;
        if (im > lim) im = lim;
        if (im < -lim) im = -lim;
    endtask

    // Drives one sample and waits for the result; lat is the number of
    // enabled clocks from the loading edge to oval.
    task automatic run_single(input logic [17:0] mag, input logic [29:0] ang,
                              input logic [1:0] q, output int lat);
        imag   = mag;
        iangle = ang;
        iquart = q;
        ival   = 1'b1;
        step();
        ival = 1'b0;
        lat  = 1;
        while (!oval && lat < 60) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        ireset = 1'b1;
        repeat (3) step();
        checks++;
        if (oval !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_oval: got %b expected 0", oval);
        end
        checks++;
        if (odat_re !== 20'sd0) begin
            errors++;
            $display("[TB] FAIL reset_re: got %0d expected 0", odat_re);
        end
        checks++;
        if (odat_im !== 20'sd0) begin
            errors++;
            $display("[TB] FAIL reset_im: got %0d expected 0", odat_im);
        end
        ireset = 1'b0;
        step();
    endtask

    task automatic test_quadrants();
        logic [29:0] angs [5]  = '{30'd0, 30'h2000_0000, 30'h2000_0000, 30'h2000_0000, 30'h2000_0000};
        logic [1:0]  qs   [5]  = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
        int          ere  [5]  = '{cE0, cE45, -cE45, -cE45, cE45};
        int          eim  [5]  = '{0, cE45, cE45, -cE45, -cE45};
        int          lat;
        for (int t = 0; t < 5; t++) begin
            run_single(18'd10000, angs[t], qs[t], lat);
            checks++;
            if (lat !== cLAT) begin
                errors++;
                $display("[TB] FAIL quad%0d_latency: got %0d expected %0d", t, lat, cLAT);
            end
            checks++;
            if (int'(odat_re) > ere[t] + 2 || int'(odat_re) < ere[t] - 2) begin
                errors++;
                $display("[TB] FAIL quad%0d_re: got %0d expected %0d+-2", t, odat_re, ere[t]);
            end
            checks++;
            if (int'(odat_im) > eim[t] + 2 || int'(odat_im) < eim[t] - 2) begin
                errors++;
                $display("[TB] FAIL quad%0d_im: got %0d expected %0d+-2", t, odat_im, eim[t]);
            end
        end
    endtask

    task automatic test_saturation();
        int  lat;
        real mre;
        real mim;
        real d;
        logic [1:0] qs [2] = '{2'b00, 2'b11};
        for (int t = 0; t < 2; t++) begin
            run_single(18'd262143, 30'd0, qs[t], lat);
            model(262143, 30'd0, qs[t], 19, mre, mim);
            checks++;
            if (!cCOMP) begin
                if (int'(re19) !== ((t == 0) ? 262143 : -262143)) begin
                    errors++;
                    $display("[TB] FAIL sat%0d_re19: got %0d expected %0d", t, re19,
                             (t == 0) ? 262143 : -262143);
                end
            end else begin
                d = real'(re19) - mre;
                if (d > 2.0 || d < -2.0) begin
                    errors++;
                    $display("[TB] FAIL sat%0d_re19: got %0d expected %0f+-2", t, re19, mre);
                end
            end
            checks++;
            if (int'(im19) > 2 || int'(im19) < -2) begin
                errors++;
                $display("[TB] FAIL sat%0d_im19: got %0d expected 0+-2", t, im19);
            end
            // The 20-bit instance has enough range and must not clip.
            model(262143, 30'd0, qs[t], 20, mre, mim);
            d = real'(odat_re) - mre;
            checks++;
            if (d > 3.0 || d < -3.0) begin
                errors++;
                $display("[TB] FAIL sat%0d_re20: got %0d expected %0f+-3", t, odat_re, mre);
            end
        end
    endtask

    task automatic test_back_to_back();
        real         exp_re [$];
        real         exp_im [$];
        int          sent  = 0;
        int          got   = 0;
        int          cyc   = 0;
        int          first = -1;
        int          last  = -1;
        int          mag;
        logic [29:0] ang;
        logic [1:0]  q;
        real         mre;
        real         mim;
        real         d;
        while (got < 64 && cyc < 300) begin
            if (sent < 64) begin
                mag = int'($urandom_range(0, 262143));
                ang = 30'($urandom());
                q   = 2'($urandom());
                model(mag, ang, q, 20, mre, mim);
                exp_re.push_back(mre);
                exp_im.push_back(mim);
                imag   = 18'(mag);
                iangle = ang;
                iquart = q;
                ival   = 1'b1;
                sent++;
            end else begin
                ival = 1'b0;
            end
            step();
            cyc++;
            if (oval && exp_re.size() > 0) begin
                if (first < 0) first = cyc;
                last = cyc;
                mre  = exp_re.pop_front();
                mim  = exp_im.pop_front();
                d    = real'(odat_re) - mre;
                checks++;
                if (d > 3.0 || d < -3.0) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_re: got %0d expected %0f+-3", got, odat_re, mre);
                end
                d = real'(odat_im) - mim;
                checks++;
                if (d > 3.0 || d < -3.0) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_im: got %0d expected %0f+-3", got, odat_im, mim);
                end
                got++;
            end
        end
        ival = 1'b0;
        checks++;
        if (got !== 64) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results expected 64", got);
        end
        checks++;
        if (last - first !== 63) begin
            errors++;
            $display("[TB] FAIL b2b_contiguous: got span %0d expected 63", last - first);
        end
        checks++;
        if (first !== cLAT) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d expected %0d", first, cLAT);
        end
        step();
    endtask

    task automatic test_clkena_gap();
        logic [17:0]        mags [10];
        logic [29:0]        angs [10];
        logic [1:0]         qs   [10];
        logic signed [19:0] ref_re [10];
        logic signed [19:0] ref_im [10];
        real                mre;
        real                mim;
        real                d;
        for (int s = 0; s < 10; s++) begin
            mags[s] = 18'($urandom());
            angs[s] = 30'($urandom());
            qs[s]   = 2'($urandom());
        end
        for (int pass = 0; pass < 2; pass++) begin
            int   idx    = 0;
            int   got    = 0;
            int   c      = 0;
            int   og     = -1;
            bit   en_now;
            logic               s_val;
            logic signed [19:0] s_re;
            logic signed [19:0] s_im;
            while (got < 10 && c < 200) begin
                en_now = (pass == 0) ||
                         !((c >= 5 && c < 10) || (og >= 0 && c >= og && c < og + 5));
                iclkena = en_now;
                if (idx < 10) begin
                    imag   = mags[idx];
                    iangle = angs[idx];
                    iquart = qs[idx];
                    ival   = 1'b1;
                end else begin
                    ival = 1'b0;
                end
                s_val = oval;
                s_re  = odat_re;
                s_im  = odat_im;
                step();
                c++;
                if (en_now) begin
                    if (idx < 10) idx++;
                    if (oval) begin
                        if (pass == 0) begin
                            ref_re[got] = odat_re;
                            ref_im[got] = odat_im;
                            model(int'(mags[got]), angs[got], qs[got], 20, mre, mim);
                            d = real'(odat_re) - mre;
                            checks++;
                            if (d > 3.0 || d < -3.0) begin
                                errors++;
                                $display("[TB] FAIL burst%0d_model_re: got %0d expected %0f+-3",
                                         got, odat_re, mre);
                            end
                        end else begin
                            checks++;
                            if (odat_re !== ref_re[got] || odat_im !== ref_im[got]) begin
                                errors++;
                                $display("[TB] FAIL gap%0d_exact: got %0d/%0d expected %0d/%0d",
                                         got, odat_re, odat_im, ref_re[got], ref_im[got]);
                            end
                        end
                        got++;
                        if (pass == 1 && got == 3 && og < 0) og = c;
                    end
                end else begin
                    checks++;
                    if (oval !== s_val || odat_re !== s_re || odat_im !== s_im) begin
                        errors++;
                        $display("[TB] FAIL gap_freeze_c%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                                 c, oval, odat_re, odat_im, s_val, s_re, s_im);
                    end
                end
            end
            iclkena = 1'b1;
            ival    = 1'b0;
            checks++;
            if (got !== 10) begin
                errors++;
                $display("[TB] FAIL burst_count_pass%0d: got %0d expected 10", pass, got);
            end
            repeat (3) step();
        end
    endtask

    task automatic test_reset_midstream();
        int  stale = 0;
        int  lat;
        real mre;
        real mim;
        real d;
        for (int s = 0; s < 8; s++) begin
            imag   = 18'($urandom());
            iangle = 30'($urandom());
            iquart = 2'($urandom());
            ival   = 1'b1;
            step();
        end
        ival = 1'b0;
        repeat (3) step();
        #2;
        ireset = 1'b1;
        #1;
        checks++;
        if (oval !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_oval: got %b expected 0", oval);
        end
        checks++;
        if (odat_re !== 20'sd0 || odat_im !== 20'sd0) begin
            errors++;
            $display("[TB] FAIL midreset_dat: got %0d/%0d expected 0/0", odat_re, odat_im);
        end
        repeat (2) step();
        ireset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (oval) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_stale: got %0d oval cycles expected 0", stale);
        end
        run_single(18'd12345, 30'h1555_5555, 2'b01, lat);
        checks++;
        if (lat !== cLAT) begin
            errors++;
            $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, cLAT);
        end
        model(12345, 30'h1555_5555, 2'b01, 20, mre, mim);
        d = real'(odat_re) - mre;
        checks++;
        if (d > 3.0 || d < -3.0) begin
            errors++;
            $display("[TB] FAIL midreset_re: got %0d expected %0f+-3", odat_re, mre);
        end
        d = real'(odat_im) - mim;
        checks++;
        if (d > 3.0 || d < -3.0) begin
            errors++;
            $display("[TB] FAIL midreset_im: got %0d expected %0f+-3", odat_im, mim);
        end
    endtask

    initial begin
        gain = 1.0;
        for (int i = 0; i < 20; i++) begin
            gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * real'(i)));
        end
        if (cCOMP) gain = gain * 79594.0 / 131072.0;

        test_reset();
        test_quadrants();
        test_saturation();
        test_back_to_back();
        test_clkena_gap();
        test_reset_midstream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
